fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter ADDRSIZE, default 8, giving the FIFO address width (used only for the level compare).
REQ-002 The block SHALL have parameter DSIZE, default 8, giving the data width per beat.
REQ-003 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-004 wclk  input  1  write-domain clock; all logic on rising edge.
REQ-005 wrst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  NREQ  per-requester beat-valid.
REQ-007 last  input  NREQ  per-requester end-of-packet marker, qualified by req.
REQ-008 din  input  NREQ*DSIZE  per-requester data; requester i at bits [i*DSIZE +: DSIZE].
REQ-009 wfull  input  1  FIFO full flag from the write-pointer block.
REQ-010 gnt  output  NREQ  one-hot beat accept; gnt[i]=1 means the beat of requester i is consumed this cycle.
REQ-011 winc  output  1  FIFO write increment.
REQ-012 wdata  output  DSIZE  FIFO write data.
REQ-013 owner  output  3  index of the current burst owner, valid while busy=1.
REQ-014 busy  output  1  1 while in state BURST.
REQ-015 timeout_err  output  1  one-cycle pulse on a forced release (see Configuration).

Function
REQ-016 The FSM SHALL have two states: IDLE and BURST.
REQ-017 In IDLE with any req set, the block SHALL pick the first set req at or after rr_ptr, searching upward modulo NREQ, register it into owner, and enter BURST on the next edge.
REQ-018 Arbitration latency SHALL be one cycle; no beat is accepted in IDLE.
REQ-019 In BURST, gnt[owner], winc and the accept condition SHALL all equal req[owner] & ~wfull, combinationally; all other gnt bits SHALL be 0.
REQ-020 wdata SHALL equal din[owner] combinationally while busy, and 0 otherwise.
REQ-021 An accepted beat with last[owner]=1 SHALL return the FSM to IDLE and set rr_ptr to (owner+1) mod NREQ at the same edge.
REQ-022 The owner SHALL keep the lock through req gaps and through wfull stalls; a packet is never interleaved with another.
REQ-023 With wfull=1, winc SHALL be 0 and no gnt SHALL be asserted.
REQ-024 A requester that raises req while another requester owns the burst SHALL wait until the FSM returns to IDLE.
REQ-025 Back-to-back packets SHALL have a one-cycle IDLE bubble between them.

Reset
REQ-026 On wrst_n low, the block SHALL asynchronously set state=IDLE, rr_ptr=0, owner=0, busy=0, timeout_err=0, idle counter=0.
REQ-027 Also on wrst_n low, gnt, winc and wdata SHALL be 0.
REQ-028 Reset mid-burst SHALL abandon the packet with no further winc.

Configuration
REQ-029 With macro WR_ARB_TIMEOUT_EN defined, a 4-bit counter SHALL count BURST cycles with req[owner]=0.
REQ-030 The counter SHALL clear on any cycle with req[owner]=1, independent of wfull.
REQ-031 When the counter would reach 16, the block SHALL force IDLE, advance rr_ptr as in REQ-021, and pulse timeout_err for one cycle.
REQ-032 Without WR_ARB_TIMEOUT_EN, the counter SHALL be absent, timeout_err SHALL be tied 0, and the lock SHALL persist indefinitely.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE, BURST) and the timeout limit constant (16).
REQ-034 The round-robin next-index search SHALL be one sub-module, rr_pick (inputs: req and ptr; output: index and valid).
REQ-035 The arbiter SHALL contain no FIFO storage and no pointer logic; it feeds winc and wdata to the existing write-pointer block.

Verification
REQ-036 Scenario 1: reset, then req=0001 with last on the 3rd beat and wfull=0 -> busy rises 1 cycle later, exactly 3 winc pulses, then IDLE, rr_ptr=1.
REQ-037 Scenario 2: req=1111 continuously, single-beat packets -> owner sequence 0,1,2,3,0, each grant separated by one idle cycle.
REQ-038 Scenario 3: owner 2 mid-packet while wfull=1 for 5 cycles -> winc=0 and gnt=0 for those 5 cycles, and the packet resumes with no beat lost or duplicated.
REQ-039 Scenario 4: owner 1 mid-packet and req[3] rises -> no gnt[3] until owner 1 accepts its last beat, and req[3] is served next.
REQ-040 Scenario 5 (WR_ARB_TIMEOUT_EN defined): owner drops req for 16 cycles -> timeout_err pulses once and the FSM returns to IDLE; with the macro undefined, the FSM stays in BURST.
REQ-041 Scenario 6: wrst_n asserted mid-burst -> all outputs reach their REQ-026/REQ-027 values immediately and arbitration restarts from requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared state type, timeout limit and round-robin helper
package fifo_wr_arbiter_pkg;

  // Arbiter FSM: IDLE picks a requester, BURST holds the lock until the packet ends
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Consecutive owner-silent BURST cycles that force a release
  localparam int unsigned TIMEOUT_LIMIT = 16;

  // Index following idx in a ring of nreq requesters
  function automatic logic [2:0] rr_next(input logic [2:0] idx, input int unsigned nreq);
    logic [3:0] nxt;
    nxt = {1'b0, idx} + 4'd1;
    if (nxt >= 4'(nreq)) begin
      nxt = 4'd0;
    end
    return nxt[2:0];
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - round-robin search for the first set request at or after ptr
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [2:0]      idx,
  output logic            valid
);

  logic [7:0] w_req_pad;
  logic [3:0] w_pos;

  // Widen the request vector to the full 3-bit index space so any index is in range
  always_comb begin
    w_req_pad             = '0;
    w_req_pad[NREQ-1:0]   = req;
  end

  // Walk the ring from the farthest offset down to ptr so the nearest hit wins
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    w_pos = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_pos = {1'b0, ptr} + 4'(k);
      if (w_pos >= 4'(NREQ)) begin
        w_pos = w_pos - 4'(NREQ);
      end
      if (w_req_pad[w_pos[2:0]]) begin
        idx   = w_pos[2:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - packet-locking round-robin write arbiter in front of an async FIFO; optional owner timeout under WR_ARB_TIMEOUT_EN
module fifo_wr_arbiter #(
  parameter int ADDRSIZE = 8,
  parameter int DSIZE    = 8,
  parameter int NREQ     = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       last,
  input  logic [NREQ*DSIZE-1:0] din,
  input  logic                  wfull,
  output logic [NREQ-1:0]       gnt,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [2:0]            owner,
  output logic                  busy,
  output logic                  timeout_err
);

  import fifo_wr_arbiter_pkg::*;

  // Reject configurations the 3-bit owner index and the FIFO cannot represent
  if (NREQ < 2 || NREQ > 8 || ADDRSIZE < 1 || DSIZE < 1) begin : g_param_check
    $error("fifo_wr_arbiter: unsupported NREQ/ADDRSIZE/DSIZE");
  end

  arb_state_e r_state;
  logic [2:0] r_rr_ptr;
  logic [2:0] r_owner;

  logic [7:0] w_req_pad;
  logic [7:0] w_last_pad;
  logic       w_req_own;
  logic       w_last_own;
  logic       w_busy;
  logic       w_accept;
  logic       w_release;
  logic [2:0] w_pick_idx;
  logic       w_pick_valid;

  // Widen per-requester flags so the owner index always selects a real bit
  always_comb begin
    w_req_pad             = '0;
    w_last_pad            = '0;
    w_req_pad[NREQ-1:0]   = req;
    w_last_pad[NREQ-1:0]  = last;
  end

  assign w_req_own  = w_req_pad[r_owner];
  assign w_last_own = w_last_pad[r_owner];
  assign w_busy     = (r_state == ST_BURST);
  // A beat moves only while locked, the owner presents data, and the FIFO has room
  assign w_accept   = w_busy & w_req_own & ~wfull;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req   (req),
    .ptr   (r_rr_ptr),
    .idx   (w_pick_idx),
    .valid (w_pick_valid)
  );

`ifdef WR_ARB_TIMEOUT_EN
  logic [3:0] r_idle_cnt;
  logic       r_timeout_err;
  logic       w_timeout_hit;

  // The 16th consecutive silent BURST cycle releases the lock
  assign w_timeout_hit = w_busy & ~w_req_own & (r_idle_cnt == 4'(TIMEOUT_LIMIT - 1));
  assign w_release     = (w_accept & w_last_own) | w_timeout_hit;
  assign timeout_err   = r_timeout_err;

  // Count owner-silent BURST cycles; any owner request clears it, stalled or not
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_idle_cnt <= '0;
    end else if (!w_busy || w_req_own || w_timeout_hit) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 4'd1;
    end
  end

  // One-cycle error pulse in the cycle after a forced release
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout_hit;
    end
  end
`else
  assign w_release   = w_accept & w_last_own;
  assign timeout_err = 1'b0;
`endif

  // Lock a requester from IDLE, hold it through gaps and stalls, release on its last beat
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_owner <= w_pick_idx;
            r_state <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_release) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= rr_next(r_owner, NREQ);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Only the owner's grant bit can be high, and only on an accepted beat
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == 3'(i)) begin
        gnt[i] = w_accept;
      end
    end
  end

  // Route the owner's data to the FIFO while locked; drive zero otherwise
  always_comb begin
    wdata = '0;
    if (w_busy) begin
      for (int i = 0; i < NREQ; i++) begin
        if (r_owner == 3'(i)) begin
          wdata = din[i*DSIZE +: DSIZE];
        end
      end
    end
  end

  assign winc  = w_accept;
  assign owner = r_owner;
  assign busy  = w_busy;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       last;
  logic [NREQ*DSIZE-1:0] din;
  logic                  wfull;
  logic [NREQ-1:0]       gnt;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [2:0]            owner;
  logic                  busy;
  logic                  timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int wcnt     = 0;
  int w0;

  fifo_wr_arbiter #(
    .ADDRSIZE (8),
    .DSIZE    (DSIZE),
    .NREQ     (NREQ)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .req         (req),
    .last        (last),
    .din         (din),
    .wfull       (wfull),
    .gnt         (gnt),
    .winc        (winc),
    .wdata       (wdata),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 wclk = ~wclk;

  always @(negedge wclk) begin
    if (winc) wcnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_din(input int idx, input logic [7:0] val);
    din[idx*DSIZE +: DSIZE] = val;
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_gnt"},  32'(gnt),  32'd0);
    check({tag, "_winc"}, 32'(winc), 32'd0);
  endtask

  task automatic chk_beat(input string tag, input int own, input logic [7:0] data);
    check({tag, "_busy"},  32'(busy),  32'd1);
    check({tag, "_owner"}, 32'(owner), 32'(own));
    check({tag, "_gnt"},   32'(gnt),   32'(1 << own));
    check({tag, "_winc"},  32'(winc),  32'd1);
    check({tag, "_wdata"}, 32'(wdata), 32'(data));
  endtask

  task automatic chk_stall(input string tag, input int own);
    check({tag, "_busy"},  32'(busy),  32'd1);
    check({tag, "_owner"}, 32'(owner), 32'(own));
    check({tag, "_gnt"},   32'(gnt),   32'd0);
    check({tag, "_winc"},  32'(winc),  32'd0);
  endtask

  initial begin
    wrst_n = 1'b0;
    req    = '0;
    last   = '0;
    din    = '0;
    wfull  = 1'b0;
    tick();
    tick();
    settle();
    chk_idle("rst");
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_terr",  32'(timeout_err), 32'd0);
    wrst_n = 1'b1;

    // Scenario 1: three-beat packet from requester 0
    w0 = wcnt;
    req = 4'b0001;
    set_din(0, 8'hA1);
    settle();
    chk_idle("s1_arb");
    tick(); settle();
    chk_beat("s1_b0", 0, 8'hA1);
    tick(); set_din(0, 8'hA2); settle();
    chk_beat("s1_b1", 0, 8'hA2);
    tick(); set_din(0, 8'hA3); last = 4'b0001; settle();
    chk_beat("s1_b2", 0, 8'hA3);
    tick(); req = '0; last = '0; settle();
    chk_idle("s1_done");
    check("s1_winc_cnt", 32'(wcnt - w0), 32'd3);
    // rr_ptr is now 1: requesters 0 and 1 both asking must pick 1
    req = 4'b0011; last = 4'b0011; set_din(1, 8'hB1); settle();
    tick(); settle();
    chk_beat("s1_rrptr", 1, 8'hB1);
    tick(); req = '0; last = '0; settle();
    chk_idle("s1_rr_done");
    wrst_n = 1'b0;
    tick();
    wrst_n = 1'b1;

    // Scenario 2: all requesting single-beat packets, owners rotate with a bubble
    req = 4'b1111; last = 4'b1111;
    din = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 5; k++) begin
      settle();
      chk_idle($sformatf("s2_bubble%0d", k));
      tick(); settle();
      chk_beat($sformatf("s2_grant%0d", k), k % 4, 8'(8'h10 + (k % 4)));
      tick();
    end
    req = '0; last = '0; settle();

    // Scenario 3: requester 2 stalled by wfull for five cycles
    req = 4'b0100; set_din(2, 8'h30); settle();
    chk_idle("s3_arb");
    tick(); settle();
    chk_beat("s3_b0", 2, 8'h30);
    tick(); set_din(2, 8'h31); wfull = 1'b1; w0 = wcnt;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk_stall($sformatf("s3_full%0d", i), 2);
      tick();
    end
    wfull = 1'b0; settle();
    chk_beat("s3_b1", 2, 8'h31);
    tick(); set_din(2, 8'h32); last = 4'b0100; settle();
    chk_beat("s3_b2", 2, 8'h32);
    tick(); req = '0; last = '0; settle();
    chk_idle("s3_done");
    check("s3_winc_cnt", 32'(wcnt - w0), 32'd2);

    // Scenario 4: requester 3 arrives while requester 1 owns the lock
    req = 4'b0010; set_din(1, 8'h40); settle();
    tick(); settle();
    chk_beat("s4_b0", 1, 8'h40);
    tick(); req = 4'b1010; set_din(1, 8'h41); set_din(3, 8'h70); settle();
    chk_beat("s4_b1", 1, 8'h41);
    tick(); req = 4'b1000; settle();
    chk_stall("s4_gap", 1);
    tick(); req = 4'b1010; last = 4'b0010; set_din(1, 8'h42); settle();
    chk_beat("s4_last", 1, 8'h42);
    tick(); req = 4'b1000; last = 4'b1000; settle();
    chk_idle("s4_bubble");
    tick(); settle();
    chk_beat("s4_next", 3, 8'h70);
    tick(); req = '0; last = '0; settle();
    chk_idle("s4_done");

    // Scenario 5: owner 0 goes silent for 16 cycles
    req = 4'b0001; set_din(0, 8'h50); settle();
    tick(); settle();
    chk_beat("s5_b0", 0, 8'h50);
    tick(); req = '0; settle();
    chk_stall("s5_quiet", 0);
    for (int i = 0; i < 15; i++) begin
      tick(); settle();
      check($sformatf("s5_hold%0d_busy", i), 32'(busy), 32'd1);
      check($sformatf("s5_hold%0d_terr", i), 32'(timeout_err), 32'd0);
    end
    tick(); settle();
`ifdef WR_ARB_TIMEOUT_EN
    check("s5_to_busy", 32'(busy), 32'd0);
    check("s5_to_terr", 32'(timeout_err), 32'd1);
    tick(); settle();
    check("s5_after_terr", 32'(timeout_err), 32'd0);
    check("s5_after_busy", 32'(busy), 32'd0);
`else
    check("s5_lock_busy", 32'(busy), 32'd1);
    check("s5_lock_terr", 32'(timeout_err), 32'd0);
    tick(); settle();
    check("s5_lock2_busy", 32'(busy), 32'd1);
    req = 4'b0001; last = 4'b0001; set_din(0, 8'h51); settle();
    chk_beat("s5_end", 0, 8'h51);
    tick(); req = '0; last = '0; settle();
    chk_idle("s5_done");
`endif

    // Scenario 6: reset in the middle of requester 2's burst
    req = 4'b0100; set_din(2, 8'h66); settle();
    tick(); settle();
    chk_beat("s6_b0", 2, 8'h66);
    w0 = wcnt;
    wrst_n = 1'b0;
    #1;
    chk_idle("s6_rst");
    check("s6_rst_wdata", 32'(wdata), 32'd0);
    check("s6_rst_owner", 32'(owner), 32'd0);
    check("s6_rst_terr",  32'(timeout_err), 32'd0);
    tick();
    tick();
    wrst_n = 1'b1;
    check("s6_rst_winc_cnt", 32'(wcnt - w0), 32'd0);
    req = 4'b0110; set_din(1, 8'h61); settle();
    chk_idle("s6_arb");
    tick(); settle();
    chk_beat("s6_restart", 1, 8'h61);
    tick(); req = '0; settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
